// File: rtl/retire_stage_v2.sv
// retire_stage_v2
//   In-order retirement stage between the ROB head and the architectural
//   commit side. Each cycle it retires up to RETIRE_WIDTH completed slots,
//   compacts the freed physical tags, throttles stores against store-queue
//   credits, and ends the group at a halt, illegal or mispredict.
//
// Ports
//   clock, reset        : posedge clock, asynchronous active-high reset
//   rob_*               : ROB head slots, slot 0 oldest (flattened per slot)
//   complete_bits       : per physical tag, producer has completed
//   sq_credits          : stores the store queue accepts this cycle
//   rf_read_idx/data    : same-cycle regfile read of retiring t_new tags
//   num_retiring        : slots popped this cycle (combinational)
//   num_store_retiring  : stores released this cycle (combinational)
//   phys_free/num_freed : compacted t_old list (combinational)
//   commit_*            : registered commit trace, one cycle after retire
//   flush               : registered one-cycle squash after a mispredict
//   halted              : sticky halted state
//   retired_count       : running retired-instruction count (wraps)
module retire_stage_v2 #(
   parameter int unsigned RETIRE_WIDTH = 2,
   parameter int unsigned PHYS_REGS    = 64,
   parameter int unsigned CNT_W        = 32,
   localparam int unsigned PREG_BITS   = $clog2(PHYS_REGS),
   localparam int unsigned CW          = $clog2(RETIRE_WIDTH + 1),
   localparam int unsigned W           = RETIRE_WIDTH
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [CW-1:0]          rob_valid_count,
   input  logic [W*PREG_BITS-1:0] rob_t_new,
   input  logic [W*PREG_BITS-1:0] rob_t_old,
   input  logic [W*5-1:0]         rob_arch_reg,
   input  logic [W*32-1:0]        rob_npc,
   input  logic [W-1:0]           rob_has_dest,
   input  logic [W-1:0]           rob_is_store,
   input  logic [W-1:0]           rob_halt,
   input  logic [W-1:0]           rob_illegal,
   input  logic [W-1:0]           rob_mispredict,
   input  logic [PHYS_REGS-1:0]   complete_bits,
   input  logic [CW-1:0]          sq_credits,
   output logic [W*PREG_BITS-1:0] rf_read_idx,
   input  logic [W*32-1:0]        rf_read_data,
   output logic [CW-1:0]          num_retiring,
   output logic [CW-1:0]          num_store_retiring,
   output logic [W*PREG_BITS-1:0] phys_free,
   output logic [CW-1:0]          num_freed,
   output logic [W-1:0]           commit_valid,
   output logic [W*32-1:0]        commit_data,
   output logic [W*5-1:0]         commit_reg,
   output logic [W*32-1:0]        commit_npc,
   output logic [W-1:0]           commit_halt,
   output logic [W-1:0]           commit_illegal,
   output logic                   flush,
   output logic                   halted,
   output logic [CNT_W-1:0]       retired_count
);

   logic [W-1:0]           retire;
   logic [W*32-1:0]        data_d;
   logic [W*5-1:0]         reg_d;
   logic [W*32-1:0]        npc_d;
   logic [PREG_BITS-1:0]   t_new;
   logic                   go;
   int unsigned            n_ret;
   int unsigned            n_st;
   int unsigned            n_free;

   // In-order scan: once a slot fails or ends the group, 'go' drops and
   // every younger slot is left at zero.
   always_comb begin
      retire      = '0;
      rf_read_idx = '0;
      phys_free   = '0;
      data_d      = '0;
      reg_d       = '0;
      npc_d       = '0;
      t_new       = '0;
      n_ret       = 0;
      n_st        = 0;
      n_free      = 0;
      go          = !reset && !halted && !flush;
      for (int unsigned i = 0; i < W; i++) begin
         if (go) begin
            t_new = rob_t_new[i*PREG_BITS +: PREG_BITS];
            if ((CW'(i) < rob_valid_count) && complete_bits[t_new] &&
                (!rob_is_store[i] || (n_st < 32'(sq_credits)))) begin
               retire[i]                             = 1'b1;
               rf_read_idx[i*PREG_BITS +: PREG_BITS] = t_new;
               data_d[i*32 +: 32]                    = rf_read_data[i*32 +: 32];
               reg_d[i*5 +: 5]                       = rob_arch_reg[i*5 +: 5];
               npc_d[i*32 +: 32]                     = rob_npc[i*32 +: 32];
               if (rob_has_dest[i]) begin
                  phys_free[n_free*PREG_BITS +: PREG_BITS] =
                     rob_t_old[i*PREG_BITS +: PREG_BITS];
                  n_free = n_free + 1;
               end
               if (rob_is_store[i]) begin
                  n_st = n_st + 1;
               end
               n_ret = n_ret + 1;
               if (rob_halt[i] || rob_illegal[i] || rob_mispredict[i]) begin
                  go = 1'b0;
               end
            end else begin
               go = 1'b0;
            end
         end
      end
      num_retiring       = CW'(n_ret);
      num_store_retiring = CW'(n_st);
      num_freed          = CW'(n_free);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         commit_valid   <= '0;
         commit_data    <= '0;
         commit_reg     <= '0;
         commit_npc     <= '0;
         commit_halt    <= '0;
         commit_illegal <= '0;
         flush          <= 1'b0;
         halted         <= 1'b0;
         retired_count  <= '0;
      end else begin
         commit_valid   <= retire;
         commit_data    <= data_d;
         commit_reg     <= reg_d;
         commit_npc     <= npc_d;
         commit_halt    <= rob_halt & retire;
         commit_illegal <= rob_illegal & retire;
         flush          <= |(rob_mispredict & retire);
         halted         <= halted | (|((rob_halt | rob_illegal) & retire));
         retired_count  <= retired_count + CNT_W'(n_ret);
      end
   end

endmodule

// File: tb/tb_retire_stage_v2.sv
// tb_retire_stage_v2
//   Directed-vector bench for retire_stage_v2 with W=2, 64 physical regs.
module tb_retire_stage_v2;

   localparam int unsigned W  = 2;
   localparam int unsigned PB = 6;
   localparam int unsigned CW = 2;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [CW-1:0]   rob_valid_count = '0;
   logic [W*PB-1:0] rob_t_new = '0;
   logic [W*PB-1:0] rob_t_old = '0;
   logic [W*5-1:0]  rob_arch_reg = '0;
   logic [W*32-1:0] rob_npc = '0;
   logic [W-1:0]    rob_has_dest = '0;
   logic [W-1:0]    rob_is_store = '0;
   logic [W-1:0]    rob_halt = '0;
   logic [W-1:0]    rob_illegal = '0;
   logic [W-1:0]    rob_mispredict = '0;
   logic [63:0]     complete_bits = '0;
   logic [CW-1:0]   sq_credits = '0;
   logic [W*PB-1:0] rf_read_idx;
   logic [W*32-1:0] rf_read_data = '0;
   logic [CW-1:0]   num_retiring;
   logic [CW-1:0]   num_store_retiring;
   logic [W*PB-1:0] phys_free;
   logic [CW-1:0]   num_freed;
   logic [W-1:0]    commit_valid;
   logic [W*32-1:0] commit_data;
   logic [W*5-1:0]  commit_reg;
   logic [W*32-1:0] commit_npc;
   logic [W-1:0]    commit_halt;
   logic [W-1:0]    commit_illegal;
   logic            flush;
   logic            halted;
   logic [31:0]     retired_count;

   int errors = 0;
   int checks = 0;

   retire_stage_v2 #(.RETIRE_WIDTH(2), .PHYS_REGS(64), .CNT_W(32)) dut (
      .clock(clock), .reset(reset),
      .rob_valid_count(rob_valid_count), .rob_t_new(rob_t_new), .rob_t_old(rob_t_old),
      .rob_arch_reg(rob_arch_reg), .rob_npc(rob_npc), .rob_has_dest(rob_has_dest),
      .rob_is_store(rob_is_store), .rob_halt(rob_halt), .rob_illegal(rob_illegal),
      .rob_mispredict(rob_mispredict), .complete_bits(complete_bits),
      .sq_credits(sq_credits), .rf_read_idx(rf_read_idx), .rf_read_data(rf_read_data),
      .num_retiring(num_retiring), .num_store_retiring(num_store_retiring),
      .phys_free(phys_free), .num_freed(num_freed), .commit_valid(commit_valid),
      .commit_data(commit_data), .commit_reg(commit_reg), .commit_npc(commit_npc),
      .commit_halt(commit_halt), .commit_illegal(commit_illegal), .flush(flush),
      .halted(halted), .retired_count(retired_count)
   );

   always #5 clock = ~clock;

   // Stimulus setter only; performs no comparison.
   task automatic set_slot(input int s, input logic [5:0] tn, input logic [5:0] to,
                           input logic dest, input logic st, input logic hl,
                           input logic il, input logic mp);
      rob_t_new[s*PB +: PB]  = tn;
      rob_t_old[s*PB +: PB]  = to;
      rob_arch_reg[s*5 +: 5] = 5'(3 + s);
      rob_npc[s*32 +: 32]    = 32'h100 + 32'(4 * s);
      rob_has_dest[s]        = dest;
      rob_is_store[s]        = st;
      rob_halt[s]            = hl;
      rob_illegal[s]         = il;
      rob_mispredict[s]      = mp;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      set_slot(0, 6'd1, 6'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      set_slot(1, 6'd3, 6'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      complete_bits = '1;
      rob_valid_count = 2'd2;
      #2;
      checks++; if (num_retiring !== 2'd0) begin errors++; $display("FAIL reset_num_retiring: got %0d expected 0", num_retiring); end
      checks++; if (phys_free !== 12'd0) begin errors++; $display("FAIL reset_phys_free: got %h expected 000", phys_free); end
      checks++; if (retired_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", retired_count); end
      checks++; if ({flush, halted, commit_valid} !== 4'b0) begin errors++; $display("FAIL reset_regs: got %b expected 0000", {flush, halted, commit_valid}); end
      rob_valid_count = '0;
      complete_bits = '0;
      #2 reset = 1'b0;
      step();
   endtask

   task automatic test_alu_pair();
      set_slot(0, 6'd10, 6'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      set_slot(1, 6'd11, 6'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      complete_bits = '0;
      complete_bits[10] = 1'b1;
      complete_bits[11] = 1'b1;
      rf_read_data = {32'hBBBB0002, 32'hAAAA0001};
      rob_valid_count = 2'd2;
      #1;
      checks++; if (num_retiring !== 2'd2) begin errors++; $display("FAIL alu_num_retiring: got %0d expected 2", num_retiring); end
      checks++; if (num_freed !== 2'd2) begin errors++; $display("FAIL alu_num_freed: got %0d expected 2", num_freed); end
      checks++; if (phys_free !== {6'd9, 6'd5}) begin errors++; $display("FAIL alu_phys_free: got %h expected 245", phys_free); end
      checks++; if (rf_read_idx !== {6'd11, 6'd10}) begin errors++; $display("FAIL alu_rf_idx: got %h expected 2ca", rf_read_idx); end
      step();
      rob_valid_count = '0;
      checks++; if (commit_valid !== 2'b11) begin errors++; $display("FAIL alu_commit_valid: got %b expected 11", commit_valid); end
      checks++; if (commit_data !== {32'hBBBB0002, 32'hAAAA0001}) begin errors++; $display("FAIL alu_commit_data: got %h", commit_data); end
      checks++; if (commit_reg !== {5'd4, 5'd3}) begin errors++; $display("FAIL alu_commit_reg: got %h expected 083", commit_reg); end
      checks++; if (commit_npc !== {32'h104, 32'h100}) begin errors++; $display("FAIL alu_commit_npc: got %h", commit_npc); end
      checks++; if (retired_count !== 32'd2) begin errors++; $display("FAIL alu_count: got %0d expected 2", retired_count); end
   endtask

   task automatic test_in_order();
      set_slot(0, 6'd12, 6'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      set_slot(1, 6'd13, 6'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      complete_bits = '0;
      complete_bits[13] = 1'b1;
      rob_valid_count = 2'd2;
      #1;
      checks++; if (num_retiring !== 2'd0) begin errors++; $display("FAIL inorder_num_retiring: got %0d expected 0", num_retiring); end
      checks++; if ({num_freed, phys_free, rf_read_idx} !== 26'd0) begin errors++; $display("FAIL inorder_outputs: got %h expected 0", {num_freed, phys_free, rf_read_idx}); end
      step();
      rob_valid_count = '0;
      checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL inorder_commit_valid: got %b expected 00", commit_valid); end
      checks++; if (retired_count !== 32'd2) begin errors++; $display("FAIL inorder_count: got %0d expected 2", retired_count); end
   endtask

   task automatic test_store_credits();
      set_slot(0, 6'd20, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      set_slot(1, 6'd21, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      complete_bits = '0;
      complete_bits[20] = 1'b1;
      complete_bits[21] = 1'b1;
      sq_credits = 2'd1;
      rob_valid_count = 2'd2;
      #1;
      checks++; if (num_retiring !== 2'd1) begin errors++; $display("FAIL store_num_retiring: got %0d expected 1", num_retiring); end
      checks++; if (num_store_retiring !== 2'd1) begin errors++; $display("FAIL store_num_store: got %0d expected 1", num_store_retiring); end
      checks++; if (rf_read_idx !== {6'd0, 6'd20}) begin errors++; $display("FAIL store_rf_idx: got %h expected 014", rf_read_idx); end
      step();
      set_slot(0, 6'd21, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      set_slot(1, 6'd22, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      complete_bits[22] = 1'b1;
      sq_credits = 2'd0;
      #1;
      checks++; if ({num_retiring, num_store_retiring} !== 4'd0) begin errors++; $display("FAIL store_zero_credit: got %h expected 0", {num_retiring, num_store_retiring}); end
      sq_credits = 2'd1;
      rob_valid_count = 2'd1;
      #1;
      checks++; if ({num_retiring, num_store_retiring} !== {2'd1, 2'd1}) begin errors++; $display("FAIL store_second: got %h expected 5", {num_retiring, num_store_retiring}); end
      step();
      rob_valid_count = '0;
      checks++; if (retired_count !== 32'd4) begin errors++; $display("FAIL store_count: got %0d expected 4", retired_count); end
   endtask

   task automatic test_compaction();
      set_slot(0, 6'd22, 6'd30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      set_slot(1, 6'd23, 6'd7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      complete_bits = '0;
      complete_bits[22] = 1'b1;
      complete_bits[23] = 1'b1;
      rob_valid_count = 2'd2;
      #1;
      checks++; if (num_freed !== 2'd1) begin errors++; $display("FAIL compact_num_freed: got %0d expected 1", num_freed); end
      checks++; if (phys_free !== {6'd0, 6'd7}) begin errors++; $display("FAIL compact_phys_free: got %h expected 007", phys_free); end
      step();
      rob_valid_count = '0;
      checks++; if (retired_count !== 32'd6) begin errors++; $display("FAIL compact_count: got %0d expected 6", retired_count); end
   endtask

   task automatic test_mispredict();
      set_slot(0, 6'd24, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      set_slot(1, 6'd25, 6'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      complete_bits = '1;
      rob_valid_count = 2'd2;
      #1;
      checks++; if (num_retiring !== 2'd1) begin errors++; $display("FAIL mp_num_retiring: got %0d expected 1", num_retiring); end
      checks++; if (num_freed !== 2'd0) begin errors++; $display("FAIL mp_num_freed: got %0d expected 0", num_freed); end
      step();
      set_slot(0, 6'd26, 6'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      set_slot(1, 6'd27, 6'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      checks++; if (flush !== 1'b1) begin errors++; $display("FAIL mp_flush_high: got %b expected 1", flush); end
      checks++; if (num_retiring !== 2'd0) begin errors++; $display("FAIL mp_squash_retiring: got %0d expected 0", num_retiring); end
      checks++; if (commit_valid !== 2'b01) begin errors++; $display("FAIL mp_commit_valid: got %b expected 01", commit_valid); end
      checks++; if (retired_count !== 32'd7) begin errors++; $display("FAIL mp_count: got %0d expected 7", retired_count); end
      step();
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL mp_flush_low: got %b expected 0", flush); end
      checks++; if (num_retiring !== 2'd2) begin errors++; $display("FAIL mp_resume: got %0d expected 2", num_retiring); end
      step();
      rob_valid_count = '0;
      checks++; if (retired_count !== 32'd9) begin errors++; $display("FAIL mp_resume_count: got %0d expected 9", retired_count); end
   endtask

   task automatic test_empty();
      complete_bits = '1;
      rob_valid_count = 2'd0;
      sq_credits = 2'd2;
      #1;
      checks++; if ({num_retiring, num_store_retiring, num_freed} !== 6'd0) begin errors++; $display("FAIL empty_counts: got %h expected 0", {num_retiring, num_store_retiring, num_freed}); end
      step();
   endtask

   task automatic test_halt();
      set_slot(0, 6'd28, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      set_slot(1, 6'd29, 6'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      complete_bits = '1;
      rob_valid_count = 2'd2;
      #1;
      checks++; if (num_retiring !== 2'd1) begin errors++; $display("FAIL halt_num_retiring: got %0d expected 1", num_retiring); end
      step();
      checks++; if ({halted, flush} !== 2'b11) begin errors++; $display("FAIL halt_mp_both: got %b expected 11", {halted, flush}); end
      checks++; if (commit_halt !== 2'b01) begin errors++; $display("FAIL halt_commit_halt: got %b expected 01", commit_halt); end
      checks++; if (retired_count !== 32'd10) begin errors++; $display("FAIL halt_count: got %0d expected 10", retired_count); end
      set_slot(0, 6'd30, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      checks++; if ({halted, flush} !== 2'b10) begin errors++; $display("FAIL halt_sticky: got %b expected 10", {halted, flush}); end
      checks++; if (num_retiring !== 2'd0) begin errors++; $display("FAIL halt_blocks: got %0d expected 0", num_retiring); end
      #2 reset = 1'b1;
      #1;
      checks++; if ({halted, flush, commit_valid} !== 4'b0) begin errors++; $display("FAIL async_reset_regs: got %b expected 0000", {halted, flush, commit_valid}); end
      checks++; if (retired_count !== 32'd0) begin errors++; $display("FAIL async_reset_count: got %0d expected 0", retired_count); end
      #2 reset = 1'b0;
      rob_valid_count = '0;
      step();
   endtask

   task automatic test_illegal();
      set_slot(0, 6'd31, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      set_slot(1, 6'd32, 6'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      complete_bits = '1;
      rob_valid_count = 2'd2;
      #1;
      checks++; if (num_retiring !== 2'd1) begin errors++; $display("FAIL illegal_num_retiring: got %0d expected 1", num_retiring); end
      step();
      rob_valid_count = '0;
      checks++; if ({halted, flush, commit_illegal} !== 4'b1001) begin errors++; $display("FAIL illegal_state: got %b expected 1001", {halted, flush, commit_illegal}); end
      checks++; if (retired_count !== 32'd1) begin errors++; $display("FAIL illegal_count: got %0d expected 1", retired_count); end
   endtask

   initial begin
      test_reset();
      test_alu_pair();
      test_in_order();
      test_store_credits();
      test_compaction();
      test_mispredict();
      test_empty();
      test_halt();
      test_illegal();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation exceeded 20000 time units");
      $fatal(1);
   end

endmodule

// File: doc/retire_stage_v2.md
# retire_stage_v2

Parametrised in-order retirement stage between the ROB head and the architectural-commit side (free list, store queue, commit trace, front-end flush). Each cycle it retires up to `RETIRE_WIDTH` completed instructions from the ROB head, compacts freed physical registers, and throttles stores against store-queue drain credits. It ends a retire group at a mispredicted branch or a halt/illegal instruction, and raises a registered pipeline-flush pulse on a mispredict. It also latches the halted state and keeps a running retired-instruction count.

## Interface
- `RETIRE_WIDTH`, 2: maximum instructions retired per cycle (1..8).
- `PHYS_REGS`, 64: physical register count; `PREG_BITS = $clog2(PHYS_REGS)`.
- `CNT_W`, 32: width of the retired-instruction counter.
- `CW = $clog2(RETIRE_WIDTH+1)`: width of all count ports.
- `clock` in 1: single clock, posedge.
- `reset` in 1: asynchronous, active-high.
- `rob_valid_count` in CW: number of valid ROB head slots, slot 0 oldest.
- `rob_t_new`, `rob_t_old` in W×PREG_BITS: physical tags per slot.
- `rob_arch_reg` in W×5, `rob_npc` in W×32: architectural destination and next PC.
- `rob_has_dest`, `rob_is_store`, `rob_halt`, `rob_illegal`, `rob_mispredict` in W: per-slot flags.
- `complete_bits` in PHYS_REGS: a set bit means the tag's producer has completed.
- `sq_credits` in CW: number of stores the store queue accepts this cycle.
- `rf_read_idx` out W×PREG_BITS, `rf_read_data` in W×32: combinational regfile read port, same cycle.
- `num_retiring` out CW: slots popped from the ROB this cycle.
- `num_store_retiring` out CW: stores released to the store queue.
- `phys_free` out W×PREG_BITS, `num_freed` out CW: compacted `t_old` list. Entries `[0..num_freed-1]` are valid.
- `commit_valid` out W, `commit_data` out W×32, `commit_reg` out W×5, `commit_npc` out W×32, `commit_halt`, `commit_illegal` out W: registered commit trace.
- `flush` out 1: registered, one-cycle pipeline squash.
- `halted` out 1: sticky halted state.
- `retired_count` out CNT_W: total instructions retired since reset.

## Operation
- Slots are scanned in order from 0 to W-1. Slot i retires only if all of the following hold, and the scan stops at the first slot that fails:
  - `!halted` and `!flush`;
  - i < `rob_valid_count`;
  - `complete_bits[rob_t_new[i]]` is set;
  - no earlier slot retired this cycle had halt, illegal or mispredict set;
  - if the slot is a store, the stores already retired this cycle are fewer than `sq_credits`.
- For each retiring slot:
  - `rf_read_idx[i] = rob_t_new[i]`;
  - if `rob_has_dest`, `rob_t_old` is appended at `phys_free[num_freed]` and `num_freed` increments;
  - stores increment `num_store_retiring`.
- Halt or illegal: the instruction retires, the group ends, and `halted` is set at the next edge. It stays set until reset.
- Mispredict: the instruction retires, the group ends, and `flush` is 1 for exactly the next cycle. During that cycle `num_retiring` is 0 while the ROB squashes.
- Non-retiring slots drive all combinational outputs to 0. Unused `phys_free` entries are 0.
- `retired_count` increases by `num_retiring` each cycle and wraps modulo 2^CNT_W.

## Timing
- `num_retiring`, `num_store_retiring`, `phys_free`, `num_freed` and `rf_read_idx` are combinational, valid in the same cycle as the ROB inputs.
- Commit trace: slot i's fields and `rf_read_data[i]` are registered. They appear one cycle after retirement, with `commit_valid[i]` set only for retired slots.
- `flush`, `halted` and `retired_count` are registered and update at the edge ending the retiring cycle.
- Reset (asynchronous, any time, including mid-group) clears `commit_*`, `flush`, `halted` and `retired_count` to 0 immediately. While reset is asserted, combinational outputs are 0.
- Simultaneous halt and mispredict on one slot: both `halted` and `flush` assert next cycle.
- `sq_credits` of 0 with a store at slot 0: nothing retires, and no younger slot bypasses the store.
- When the ROB is empty (`rob_valid_count = 0`), all counts are 0.

## Test plan
- W=2, two completed ALU ops with `has_dest`, t_old 5 and 9 -> `num_retiring`=2, `phys_free`={5,9}, `num_freed`=2. Next cycle `commit_valid`=2'b11 with the regfile data; `retired_count`=2.
- Slot 0 incomplete, slot 1 complete -> `num_retiring`=0 and all outputs 0, because retirement is strictly in order.
- Two stores with `sq_credits`=1 -> `num_retiring`=1, `num_store_retiring`=1. Next cycle with `sq_credits`=1 -> the second store retires.
- Slot 0 mispredict, slot 1 complete -> `num_retiring`=1. Next cycle `flush`=1 and `num_retiring`=0 with valid inputs. The following cycle `flush`=0.
- Slot 0 halt -> retires. Next cycle `halted`=1, `commit_halt[0]`=1, and every later cycle `num_retiring`=0. Asserting reset mid-cycle clears `halted` and `retired_count` with no clock edge.
